// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit arbiter: FSM encoding, transmitter register map, status idle mask.
// Latency: none (constants and a pure helper function only).
// Backpressure: n/a.
package uart_pkg;

  // FSM encoding kept as plain vectors so older tools and waveform viewers decode it directly
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POLL  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  // Transmitter register map
  localparam logic [2:0] UART_ADDR_DATA   = 3'd0;
  localparam logic [2:0] UART_ADDR_STATUS = 3'd4;

  // Status bits that must all read 1 before a byte may be written
  localparam logic [31:0] UART_IDLE_MASK = 32'h0000_6000;

  // Byte lane 0 carries the character on a data write
  localparam logic [3:0] UART_LANE_BYTE0 = 4'b0001;

  function automatic logic tx_is_idle(input logic [31:0] rdata, input logic [31:0] mask);
    return (rdata & mask) == mask;
  endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester + transmitter bus bundle for uart_tx_arb.
// Latency: wires only.
// Backpressure: req_ready is a one-cycle accept pulse; uart_rdata returns one cycle after uart_addr.
// Ports: req_valid/req_data/req_ready (byte requesters), uart_addr/wdata/lane/wr/valid/rdata (transmitter).
// master = the arbiter, slave = requesters plus transmitter.
interface uart_tx_arb_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [2:0]        uart_addr;
  logic [31:0]       uart_wdata;
  logic [3:0]        uart_lane;
  logic              uart_wr;
  logic              uart_valid;
  logic [31:0]       uart_rdata;

  modport master (
    input  req_valid, req_data, uart_rdata,
    output req_ready, uart_addr, uart_wdata, uart_lane, uart_wr, uart_valid
  );

  modport slave (
    output req_valid, req_data, uart_rdata,
    input  req_ready, uart_addr, uart_wdata, uart_lane, uart_wr, uart_valid
  );
endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// Round-robin picker: first set request strictly after i_last, wrapping NREQ-1 -> 0; i_last itself is lowest priority.
// Latency: combinational.
// Backpressure: none; o_gnt_vld is low when no request is set.
// Ports: i_req (request vector), i_last (last grant), o_gnt_idx (winner), o_gnt_vld (any winner).
module rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [1:0]      i_last,
  output logic [1:0]      o_gnt_idx,
  output logic            o_gnt_vld
);

  // Scan from the furthest offset down to offset 1 so the nearest requester after i_last
  // is the final assignment and therefore wins.
  always_comb begin
    o_gnt_idx = i_last;
    o_gnt_vld = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (i_req[i] && (i == ((int'(i_last) + k) % NREQ))) begin
          o_gnt_idx = 2'(i);
          o_gnt_vld = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates NREQ byte requesters onto one UART transmitter: grant, poll status until idle, write, settle gap.
// Latency: grant to uart_wr 3 cycles minimum; back-to-back writes at least 6 cycles apart.
// Backpressure: requesters wait until S_IDLE grants them (req_ready pulse); transmitter throttles via status polling.
// Ports: clk, rst (sync active-high), bus (uart_tx_arb_if.master), grant_id (current/last winner), busy (not idle).
// Option: define UART_TX_ARB_LINE_LOCK_EN to hold the grant on one requester until it writes 8'h0A.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int          NREQ      = 2,
  parameter logic [31:0] IDLE_MASK = UART_IDLE_MASK
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_arb_if.master        bus,
  output logic [1:0]           grant_id,
  output logic                 busy
);

  logic [2:0] r_state;
  logic [1:0] r_last;
  logic [7:0] r_byte;
  logic       r_gap;      // second gap cycle marker

  logic [1:0] w_pick_idx;
  logic       w_pick_vld;
  logic [1:0] w_grant_idx;
  logic       w_grant_vld;
  logic       w_accept;
  logic [7:0] w_grant_byte;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .i_req     (bus.req_valid),
    .i_last    (r_last),
    .o_gnt_idx (w_pick_idx),
    .o_gnt_vld (w_pick_vld)
  );

`ifdef UART_TX_ARB_LINE_LOCK_EN
  localparam logic [7:0] LINE_END = 8'h0A;

  logic r_lock;           // owner of r_last keeps the transmitter until it sends LINE_END
  logic w_lock_req;

  always_comb begin
    w_lock_req = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_last == 2'(i)) w_lock_req = bus.req_valid[i];
    end
  end

  assign w_grant_idx = r_lock ? r_last     : w_pick_idx;
  assign w_grant_vld = r_lock ? w_lock_req : w_pick_vld;
`else
  assign w_grant_idx = w_pick_idx;
  assign w_grant_vld = w_pick_vld;
`endif

  assign w_accept = !rst && (r_state == S_IDLE) && w_grant_vld;

  always_comb begin
    w_grant_byte = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant_idx == 2'(i)) w_grant_byte = bus.req_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_last  <= 2'(NREQ - 1);
      r_byte  <= 8'h00;
      r_gap   <= 1'b0;
`ifdef UART_TX_ARB_LINE_LOCK_EN
      r_lock  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_vld) begin
            r_last  <= w_grant_idx;
            r_byte  <= w_grant_byte;
            r_state <= S_POLL;
`ifdef UART_TX_ARB_LINE_LOCK_EN
            // lock decision is known at accept time: only LINE_END releases it
            r_lock  <= (w_grant_byte != LINE_END);
`endif
          end
        end
        S_POLL:  r_state <= S_CHECK;
        // uart_rdata here answers the status read issued in S_POLL
        S_CHECK: r_state <= tx_is_idle(bus.uart_rdata, IDLE_MASK) ? S_WRITE : S_POLL;
        S_WRITE: begin
          r_state <= S_GAP;
          r_gap   <= 1'b0;
        end
        S_GAP: begin
          if (r_gap) r_state <= S_IDLE;
          r_gap <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state; gating with rst makes the reset values visible
  // in the same cycle reset is asserted, which also aborts an in-flight bus cycle at once.
  always_comb begin
    bus.req_ready  = '0;
    bus.uart_addr  = UART_ADDR_STATUS;
    bus.uart_wdata = 32'h0;
    bus.uart_lane  = 4'b0000;
    bus.uart_wr    = 1'b0;
    bus.uart_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_accept && (w_grant_idx == 2'(i))) bus.req_ready[i] = 1'b1;
    end
    if (!rst) begin
      case (r_state)
        S_POLL, S_CHECK: bus.uart_valid = 1'b1;
        S_WRITE: begin
          bus.uart_addr  = UART_ADDR_DATA;
          bus.uart_wdata = {24'h0, r_byte};
          bus.uart_lane  = UART_LANE_BYTE0;
          bus.uart_wr    = 1'b1;
          bus.uart_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = !rst && (r_state != S_IDLE);
  assign grant_id = rst ? 2'(NREQ - 1) : r_last;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: randomized byte streams checked against a queue-based arbitration model.
// Latency: n/a (bench).
// Backpressure: requester queues pop only on an observed req_ready pulse.
module tb_uart_tx_arb;
  import uart_pkg::*;

  localparam int NREQ = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant_id;
  logic       busy;

  uart_tx_arb_if #(.NREQ(NREQ)) bus ();

  uart_tx_arb #(.NREQ(NREQ), .IDLE_MASK(32'h0000_6000)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // stimulus state
  logic        drv_rst = 1'b1;
  logic [7:0]  rq [NREQ][$];
  int          busy_left = 0;
  int          busy_pct  = 0;
  logic [31:0] busy_val  = 32'h0;
  logic [31:0] idle_val  = 32'h0000_6000;

  // sampled outputs
  logic [NREQ-1:0] s_ready;
  logic            s_valid, s_wr, s_busy;
  logic [2:0]      s_addr;
  logic [3:0]      s_lane;
  logic [31:0]     s_wdata;
  logic [1:0]      s_gid;

  // observation logs
  logic [7:0] wr_log[$];
  int         wr_cyc[$];
  int         gr_idx[$];
  int         gr_cyc[$];
  int         viol = 0;

  // reference model state
  int   model_last = NREQ - 1;
  logic model_lock = 1'b0;

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    rst = drv_rst;
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0) begin
        bus.req_valid[i]       = 1'b1;
        bus.req_data[8*i +: 8] = rq[i][0];
      end else begin
        bus.req_valid[i]       = 1'b0;
        bus.req_data[8*i +: 8] = 8'($urandom);
      end
    end
    if (busy_left > 0) begin
      bus.uart_rdata = busy_val;
      busy_left--;
    end else if (int'($urandom_range(0, 99)) < busy_pct) begin
      bus.uart_rdata = busy_val;
    end else begin
      bus.uart_rdata = idle_val;
    end
    @(negedge clk);
    s_ready = bus.req_ready;
    s_valid = bus.uart_valid;
    s_wr    = bus.uart_wr;
    s_addr  = bus.uart_addr;
    s_lane  = bus.uart_lane;
    s_wdata = bus.uart_wdata;
    s_busy  = busy;
    s_gid   = grant_id;
    if ($countones(s_ready) > 1 || (s_ready != 0 && s_busy)) viol++;
    if (s_wr && !(s_valid && s_addr == 3'd0 && s_lane == 4'b0001 && s_wdata[31:8] == 24'h0)) viol++;
    if (!s_valid && (s_wr || s_addr != 3'd4)) viol++;
    for (int i = 0; i < NREQ; i++) begin
      if (s_ready[i]) begin
        gr_idx.push_back(i);
        gr_cyc.push_back(cyc);
        if (rq[i].size() > 0) void'(rq[i].pop_front());
      end
    end
    if (s_wr) begin
      wr_log.push_back(s_wdata[7:0]);
      wr_cyc.push_back(cyc);
    end
  endtask

  task automatic clear_logs();
    wr_log.delete();
    wr_cyc.delete();
    gr_idx.delete();
    gr_cyc.delete();
  endtask

  task automatic new_status_values();
    logic [31:0] v;
    v = $urandom;
    busy_val = v & ~(v[0] ? 32'h0000_2000 : 32'h0000_4000);
    idle_val = 32'h0000_6000 | $urandom;
  endtask

  task automatic do_reset();
    drv_rst = 1'b1;
    step();
    step();
    drv_rst = 1'b0;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    busy_left  = 0;
    busy_pct   = 0;
    model_last = NREQ - 1;
    model_lock = 1'b0;
    clear_logs();
  endtask

  // Model: every queued byte is visible from the start, so the write order follows purely from
  // round-robin over non-empty queues (plus line lock when that build option is on).
  task automatic run_stream(input logic check_timing, input string tag);
    logic [7:0] mq [NREQ][$];
    logic [7:0] exp_b[$];
    int         exp_i[$];
    int         p, budget, guard, j;
    logic       any;
    for (int i = 0; i < NREQ; i++) mq[i] = rq[i];
    p = model_last;
    any = 1'b1;
    while (any) begin
      j = -1;
`ifdef UART_TX_ARB_LINE_LOCK_EN
      if (model_lock) begin
        if (mq[p].size() > 0) j = p;
      end else
`endif
      for (int k = 1; k <= NREQ; k++) begin
        if (j < 0 && mq[(p + k) % NREQ].size() > 0) j = (p + k) % NREQ;
      end
      if (j < 0) begin
        any = 1'b0;
      end else begin
        exp_b.push_back(mq[j][0]);
        exp_i.push_back(j);
        model_lock = (mq[j][0] != 8'h0A);
        void'(mq[j].pop_front());
        p = j;
      end
    end
    model_last = p;
    clear_logs();
    budget = 40 * exp_b.size() + 40;
    guard  = 0;
    while (wr_log.size() < exp_b.size() && guard < budget) begin
      step();
      guard++;
    end
    checks++;
    if (guard >= budget) begin
      errors++;
      $display("FAIL %s_timeout: writes seen %0d, required %0d within %0d cycles", tag, wr_log.size(), exp_b.size(), budget);
    end
    for (int k = 0; k < 8; k++) step();
    checks++;
    if (wr_log.size() !== exp_b.size()) begin
      errors++;
      $display("FAIL %s_count: writes %0d, required %0d", tag, wr_log.size(), exp_b.size());
    end
    for (int k = 0; k < exp_b.size() && k < wr_log.size(); k++) begin
      checks++;
      if (wr_log[k] !== exp_b[k]) begin
        errors++;
        $display("FAIL %s_byte%0d: got %h, required %h", tag, k, wr_log[k], exp_b[k]);
      end
      if (k < gr_idx.size()) begin
        checks++;
        if (gr_idx[k] !== exp_i[k]) begin
          errors++;
          $display("FAIL %s_grant%0d: got requester %0d, required %0d", tag, k, gr_idx[k], exp_i[k]);
        end
        if (check_timing) begin
          checks++;
          if (wr_cyc[k] - gr_cyc[k] !== 3) begin
            errors++;
            $display("FAIL %s_latency%0d: got %0d cycles, required 3", tag, k, wr_cyc[k] - gr_cyc[k]);
          end
        end
      end
      if (k > 0) begin
        checks++;
        if (wr_cyc[k] - wr_cyc[k-1] < 6) begin
          errors++;
          $display("FAIL %s_spacing%0d: got %0d cycles, required >= 6", tag, k, wr_cyc[k] - wr_cyc[k-1]);
        end
      end
    end
    checks++;
    if (s_gid !== 2'(model_last)) begin
      errors++;
      $display("FAIL %s_grant_id: got %0d, required %0d", tag, s_gid, model_last);
    end
  endtask

  task automatic test_reset();
    logic [31:0] got[8];
    logic [31:0] req[8];
    string       nm[8];
    drv_rst = 1'b1;
    rst     = 1'b1;
    rq[0].push_back(8'h11);
    rq[1].push_back(8'h22);
    step();
    step();
    nm[0] = "rst_req_ready";  got[0] = 32'(s_ready); req[0] = 0;
    nm[1] = "rst_uart_valid"; got[1] = 32'(s_valid); req[1] = 0;
    nm[2] = "rst_uart_wr";    got[2] = 32'(s_wr);    req[2] = 0;
    nm[3] = "rst_uart_addr";  got[3] = 32'(s_addr);  req[3] = 4;
    nm[4] = "rst_uart_wdata"; got[4] = s_wdata;      req[4] = 0;
    nm[5] = "rst_uart_lane";  got[5] = 32'(s_lane);  req[5] = 0;
    nm[6] = "rst_busy";       got[6] = 32'(s_busy);  req[6] = 0;
    nm[7] = "rst_grant_id";   got[7] = 32'(s_gid);   req[7] = NREQ - 1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (got[k] !== req[k]) begin
        errors++;
        $display("FAIL %s: got %h, required %h", nm[k], got[k], req[k]);
      end
    end
    do_reset();
  endtask

  // One byte, idle transmitter: cycle-by-cycle bus shape through grant, poll, check, write, gap.
  task automatic test_single();
    logic [44:0] exp_t[7];
    logic [44:0] obs;
    exp_t[0] = {3'b001, 1'b0, 1'b0, 3'd4, 4'b0000, 32'h0,  1'b0};
    exp_t[1] = {3'b000, 1'b1, 1'b0, 3'd4, 4'b0000, 32'h0,  1'b1};
    exp_t[2] = {3'b000, 1'b1, 1'b0, 3'd4, 4'b0000, 32'h0,  1'b1};
    exp_t[3] = {3'b000, 1'b1, 1'b1, 3'd0, 4'b0001, 32'h41, 1'b1};
    exp_t[4] = {3'b000, 1'b0, 1'b0, 3'd4, 4'b0000, 32'h0,  1'b1};
    exp_t[5] = {3'b000, 1'b0, 1'b0, 3'd4, 4'b0000, 32'h0,  1'b1};
    exp_t[6] = {3'b000, 1'b0, 1'b0, 3'd4, 4'b0000, 32'h0,  1'b0};
    idle_val = 32'h0000_6000;
    rq[0].push_back(8'h41);
    for (int k = 0; k < 7; k++) begin
      step();
      obs = {s_ready, s_valid, s_wr, s_addr, s_lane, s_wdata, s_busy};
      checks++;
      if (obs !== exp_t[k]) begin
        errors++;
        $display("FAIL single_cycle%0d: got %h, required %h", k, obs, exp_t[k]);
      end
    end
    checks++;
    if (s_gid !== 2'd0) begin
      errors++;
      $display("FAIL single_grant_id: got %0d, required 0", s_gid);
    end
    model_last = 0;
    model_lock = 1'b1;
  endtask

  // Transmitter reports busy for n cycles: polling repeats, then exactly one write after the first idle sample.
  task automatic test_busy(input int n);
    int         base, c;
    logic       poll_ok;
    logic [7:0] b;
    new_status_values();
    b = 8'($urandom_range(8'h20, 8'h7E));
    c = (n <= 2) ? 2 : ((n + 1) / 2) * 2;
    base = cyc;
    busy_left = n;
    rq[0].push_back(b);
    clear_logs();
    poll_ok = 1'b1;
    for (int k = 0; k < c + 7; k++) begin
      step();
      if (k >= 1 && k <= c && (!s_valid || s_wr)) poll_ok = 1'b0;
    end
    checks++;
    if (wr_log.size() !== 1) begin
      errors++;
      $display("FAIL busy%0d_write_count: got %0d, required 1", n, wr_log.size());
    end else begin
      checks++;
      if (wr_cyc[0] !== base + c + 2) begin
        errors++;
        $display("FAIL busy%0d_write_cycle: got %0d, required %0d", n, wr_cyc[0] - base, c + 2);
      end
      checks++;
      if (wr_log[0] !== b) begin
        errors++;
        $display("FAIL busy%0d_write_byte: got %h, required %h", n, wr_log[0], b);
      end
    end
    checks++;
    if (poll_ok !== 1'b1) begin
      errors++;
      $display("FAIL busy%0d_polling: valid/wr pattern got %b, required continuous read polling", n, poll_ok);
    end
    model_last = 0;
    model_lock = (b != 8'h0A);
  endtask

  task automatic test_contention();
    do_reset();
    idle_val = 32'h0000_6000;
    for (int k = 0; k < 4; k++) begin
      rq[0].push_back(8'h61);
      rq[1].push_back(8'h62);
    end
`ifdef UART_TX_ARB_LINE_LOCK_EN
    rq[0].push_back(8'h0A);
    rq[1].push_back(8'h0A);
`endif
    run_stream(1'b1, "contention");
    checks++;
    if (wr_log.size() == 0 || wr_log[0] !== 8'h61) begin
      errors++;
      $display("FAIL contention_first: got %h, required 61", wr_log.size() ? wr_log[0] : 8'hxx);
    end
  endtask

  task automatic test_line();
    logic [7:0] exp_l[4];
`ifdef UART_TX_ARB_LINE_LOCK_EN
    exp_l = '{8'h68, 8'h69, 8'h0A, 8'h78};
`else
    exp_l = '{8'h68, 8'h78, 8'h69, 8'h0A};
`endif
    do_reset();
    idle_val = 32'h0000_6000;
    rq[0].push_back(8'h68);
    rq[0].push_back(8'h69);
    rq[0].push_back(8'h0A);
    rq[1].push_back(8'h78);
    run_stream(1'b1, "line");
    for (int k = 0; k < 4 && k < wr_log.size(); k++) begin
      checks++;
      if (wr_log[k] !== exp_l[k]) begin
        errors++;
        $display("FAIL line_order%0d: got %h, required %h", k, wr_log[k], exp_l[k]);
      end
    end
  endtask

  task automatic test_random();
    int         n;
    logic [7:0] b;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        n = $urandom_range(0, 5);
        for (int j = 0; j < n; j++) begin
          b = 8'($urandom);
`ifdef UART_TX_ARB_LINE_LOCK_EN
          if (b == 8'h0A) b = 8'h0B;
`endif
          rq[i].push_back(b);
        end
`ifdef UART_TX_ARB_LINE_LOCK_EN
        if (n > 0) rq[i].push_back(8'h0A);
`endif
      end
      new_status_values();
      busy_pct = (r % 2 == 1) ? 30 : 0;
      run_stream(busy_pct == 0, $sformatf("random%0d", r));
    end
    busy_pct = 0;
  endtask

  // Reset while the status check is in progress drops the latched byte.
  task automatic test_reset_mid();
    do_reset();
    idle_val = 32'h0000_6000;
    rq[0].push_back(8'h55);
    step();
    step();
    drv_rst = 1'b1;
    step();
    checks++;
    if (s_valid !== 1'b0 || s_wr !== 1'b0) begin
      errors++;
      $display("FAIL midrst_abort: valid/wr got %b%b, required 00", s_valid, s_wr);
    end
    drv_rst = 1'b0;
    step();
    checks++;
    if ({s_busy, s_valid} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_idle: busy/valid got %b%b, required 00", s_busy, s_valid);
    end
    checks++;
    if (s_gid !== 2'(NREQ - 1)) begin
      errors++;
      $display("FAIL midrst_grant_id: got %0d, required %0d", s_gid, NREQ - 1);
    end
    for (int k = 0; k < 10; k++) step();
    checks++;
    if (wr_log.size() !== 0 || gr_idx.size() !== 1) begin
      errors++;
      $display("FAIL midrst_no_write: writes %0d grants %0d, required 0 and 1", wr_log.size(), gr_idx.size());
    end
    model_last = NREQ - 1;
    model_lock = 1'b0;
  endtask

  task automatic test_protocol();
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL protocol: got %0d bad bus/ready cycles, required 0", viol);
    end
  endtask

  initial begin
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.uart_rdata = 32'h0;
    test_reset();
    test_single();
    test_busy(10);
    test_busy($urandom_range(3, 15));
    test_busy($urandom_range(3, 15));
    test_contention();
    test_line();
    test_random();
    test_reset_mid();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of byte requesters (2..4).
REQ-002 SHALL have parameter IDLE_MASK, default 32'h6000, status bits that must all be set for the transmitter to be idle.
REQ-003 SHALL have port clk  input  1  single clock; every register updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester byte-available flag.
REQ-006 SHALL have port req_data  input  8*NREQ  byte for requester i at bits [8i+7:8i].
REQ-007 SHALL have port req_ready  output  NREQ  one-cycle accept pulse per requester.
REQ-008 SHALL have port uart_addr  output  3  transmitter register address (0 = data, 4 = status).
REQ-009 SHALL have port uart_wdata  output  32  write data; byte in [7:0], upper bits zero.
REQ-010 SHALL have port uart_lane  output  4  byte lanes.
REQ-011 SHALL have port uart_wr  output  1  write strobe.
REQ-012 SHALL have port uart_valid  output  1  bus cycle valid.
REQ-013 SHALL have port uart_rdata  input  32  transmitter read data (registered, one cycle behind uart_addr).
REQ-014 SHALL have port grant_id  output  2  index of the current or last granted requester.
REQ-015 SHALL have port busy  output  1  high in any state other than S_IDLE.

Function
REQ-016 SHALL implement states S_IDLE, S_POLL, S_CHECK, S_WRITE and S_GAP.
REQ-017 S_IDLE: if any req_valid is set, SHALL grant round-robin starting at (last grant+1) mod NREQ, latch that byte, pulse req_ready[grant] for the same cycle, and go to S_POLL.
REQ-018 Exactly one req_ready bit SHALL be high at a time, and only in S_IDLE on a grant.
REQ-019 S_POLL: SHALL drive uart_addr=4, uart_valid=1, uart_wr=0, uart_lane=4'b0000, then go to S_CHECK.
REQ-020 S_CHECK: SHALL hold uart_addr=4; if (uart_rdata & IDLE_MASK)==IDLE_MASK go to S_WRITE, else go to S_POLL.
REQ-021 S_WRITE: for exactly one cycle SHALL drive uart_addr=0, uart_wdata={24'h0, byte}, uart_lane=4'b0001, uart_wr=1, uart_valid=1, then go to S_GAP.
REQ-022 S_GAP: SHALL wait exactly 2 cycles with uart_valid=0 so the transmitter status settles, then go to S_IDLE.
REQ-023 Outside S_POLL, S_CHECK and S_WRITE, uart_valid and uart_wr SHALL be 0 and uart_addr SHALL be 4.
REQ-024 A requester deasserting req_valid after its accept SHALL NOT affect the latched byte.
REQ-025 Minimum latency from grant to uart_wr is 3 cycles (S_IDLE, then S_POLL, S_CHECK, S_WRITE).
REQ-026 The round-robin pointer SHALL wrap from NREQ-1 to 0.

Reset
REQ-027 While rst=1, the block SHALL reset to: state S_IDLE, grant_id=NREQ-1 (so requester 0 wins first), req_ready=0, uart_valid=0, uart_wr=0, uart_addr=4, uart_wdata=0, uart_lane=0, busy=0.
REQ-028 Reset asserted mid-transfer SHALL abort at once; any latched byte not yet written SHALL be dropped.

Configuration
REQ-029 With UART_TX_ARB_LINE_LOCK_EN defined, after a grant the arbiter SHALL keep serving only that requester until it has written byte 8'h0A, and other requesters SHALL wait.
REQ-030 Without UART_TX_ARB_LINE_LOCK_EN, arbitration SHALL run per byte as in REQ-017.

Structure
REQ-031 State encoding, UART_ADDR_DATA=0, UART_ADDR_STATUS=4 and the IDLE_MASK default SHALL live in shared package uart_pkg.
REQ-032 The round-robin picker SHALL be a sub-module rr_pick (request vector and last grant in, grant index and valid out).

Verification
REQ-033 Single requester: req_valid[0]=1 with 8'h41, status idle -> req_ready[0] pulses once; uart_wr=1 with uart_wdata=32'h41 three cycles later.
REQ-034 Busy transmitter: uart_rdata=0 for 10 cycles, then 32'h6000 -> S_POLL/S_CHECK alternate; exactly one write follows the first idle sample.
REQ-035 Contention: both requesters stream, 'a' from 0 and 'b' from 1 -> writes alternate a,b,a,b starting with 'a' after reset.
REQ-036 Line lock enabled: requester 0 sends "hi\n" while 1 sends 'x' -> bytes 68,69,0A, then 78.
REQ-037 Reset pulsed in S_CHECK -> next cycle S_IDLE, uart_valid=0, no write issued, the byte is not re-requested.
REQ-038 Write spacing: with status always idle -> consecutive uart_wr pulses are at least 6 cycles apart.
